// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package ifq_pkg;

  localparam int unsigned IFQ_XLEN  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] pcplus4;
    logic [31:0]         instr;
  } ifq_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for fetch_decode_queue.
interface fetch_decode_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] pcplus4_i;
  logic [31:0]     instr_i;
  logic            flush_i;
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pcplus4_o;
  logic [31:0]     instr_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  enq_valid_i, pc_i, pcplus4_i, instr_i, flush_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, pc_o, pcplus4_o, instr_o, count_o
  );

  modport master (
    output enq_valid_i, pc_i, pcplus4_i, instr_i, flush_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, pc_o, pcplus4_o, instr_o, count_o
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular IF/ID decoupling queue with flush on redirect.
// Define IFQ_BYPASS_EN for a zero-latency empty-queue bypass. XLEN must equal ifq_pkg::IFQ_XLEN.
module fetch_decode_queue
  import ifq_pkg::*;
#(
  parameter int unsigned XLEN  = IFQ_XLEN,
  parameter int unsigned DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_queue_if.slave q
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ifq_entry_t mem_q [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q,  count_d;

  logic            head_valid;
  logic            byp;
  logic            byp_take;
  logic            enq_ready;
  logic            wr;
  logic            rd;
  ifq_entry_t      head;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcplus4;
  logic [31:0]     out_instr;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    head_valid = (count_q != '0) & ~q.flush_i;
    byp        = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp        = (count_q == '0) & q.enq_valid_i & ~q.flush_i;
`endif
    out_pc      = '0;
    out_pcplus4 = '0;
    out_instr   = NOP_INSTR;
    if (head_valid) begin
      out_pc      = head.pc;
      out_pcplus4 = head.pcplus4;
      out_instr   = head.instr;
    end else if (byp) begin
      out_pc      = q.pc_i;
      out_pcplus4 = q.pcplus4_i;
      out_instr   = q.instr_i;
    end
  end

  // A bypassed word taken by decode in the same cycle never touches storage.
  always_comb begin
    enq_ready = (count_q < cnt_t'(DEPTH));
    byp_take  = byp & q.deq_ready_i;
    wr        = q.enq_valid_i & enq_ready & ~byp_take & ~q.flush_i;
    rd        = head_valid & q.deq_ready_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (q.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(wr) - cnt_t'(rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= '{pc: q.pc_i, pcplus4: q.pcplus4_i, instr: q.instr_i};
  end

  assign q.enq_ready_o = enq_ready;
  assign q.deq_valid_o = head_valid | byp;
  assign q.pc_o        = out_pc;
  assign q.pcplus4_o   = out_pcplus4;
  assign q.instr_o     = out_instr;
  assign q.count_o     = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue (DEPTH=2); honours IFQ_BYPASS_EN if defined.
module tb_fetch_decode_queue;
  import ifq_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  fetch_decode_queue_if #(.XLEN(32), .DEPTH(2)) ifq ();

  fetch_decode_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (ifq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IFQ_BYPASS_EN
  localparam int unsigned STREAM_CNT = 0;
  localparam int unsigned BYP_VALID  = 1;
`else
  localparam int unsigned STREAM_CNT = 1;
  localparam int unsigned BYP_VALID  = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    ifq.enq_valid_i = v;
    ifq.pc_i        = pc;
    ifq.pcplus4_i   = pc + 32'd4;
    ifq.instr_i     = ins;
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] ins);
    sb.push_back('{pc: pc, pcplus4: pc + 32'd4, instr: ins});
  endtask

  // Monitor: every dequeue handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && ifq.deq_valid_o && ifq.deq_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deq: got pc %h expected no dequeue", ifq.pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("deq_pc", ifq.pc_o, e.pc);
        check("deq_pcplus4", ifq.pcplus4_o, e.pcplus4);
        check("deq_instr", ifq.instr_o, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    ifq.flush_i     = 1'b0;
    ifq.deq_ready_i = 1'b0;

    // 1: reset and idle
    #2 rst_n = 1'b0;
    #1;
    check("rst_deq_valid", 32'(ifq.deq_valid_o), 32'd0);
    check("rst_enq_ready", 32'(ifq.enq_ready_o), 32'd1);
    check("rst_count", 32'(ifq.count_o), 32'd0);
    check("rst_instr", ifq.instr_o, NOP_INSTR);
    check("rst_pc", ifq.pc_o, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_deq_valid", 32'(ifq.deq_valid_o), 32'd0);
    check("idle_instr", ifq.instr_o, NOP_INSTR);
    check("idle_count", 32'(ifq.count_o), 32'd0);

    // 2: fill to full, held-off enqueue, then drain in order
    drive(1'b1, 32'h0, 32'h0000_0001); expect_word(32'h0, 32'h0000_0001);
    step();
    drive(1'b1, 32'h4, 32'h0000_0002); expect_word(32'h4, 32'h0000_0002);
    step();
    drive(1'b1, 32'h8, 32'h0000_0003);
    check("full_count", 32'(ifq.count_o), 32'd2);
    check("full_enq_ready", 32'(ifq.enq_ready_o), 32'd0);
    step();
    check("held_count", 32'(ifq.count_o), 32'd2);
    check("held_head_pc", ifq.pc_o, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    ifq.deq_ready_i = 1'b1;
    step();
    check("drain1_count", 32'(ifq.count_o), 32'd1);
    step();
    check("drain2_count", 32'(ifq.count_o), 32'd0);

    // 3: streaming with wrap-around
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i) * 32'd4, 32'h0010_0093 + 32'(i));
      expect_word(32'h100 + 32'(i) * 32'd4, 32'h0010_0093 + 32'(i));
      step();
      check("stream_count", 32'(ifq.count_o), 32'(STREAM_CNT));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_end_count", 32'(ifq.count_o), 32'd0);

    // 4: flush with two stored entries and a concurrent enqueue
    ifq.deq_ready_i = 1'b0;
    drive(1'b1, 32'h180, 32'h0000_0111);
    step();
    drive(1'b1, 32'h184, 32'h0000_0222);
    step();
    check("preflush_count", 32'(ifq.count_o), 32'd2);
    drive(1'b1, 32'h200, 32'h0000_0333);
    ifq.flush_i     = 1'b1;
    ifq.deq_ready_i = 1'b1;
    #1;
    check("flush_deq_valid", 32'(ifq.deq_valid_o), 32'd0);
    check("flush_instr", ifq.instr_o, NOP_INSTR);
    check("flush_pc", ifq.pc_o, 32'd0);
    step();
    ifq.flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("postflush_count", 32'(ifq.count_o), 32'd0);
    check("postflush_deq_valid", 32'(ifq.deq_valid_o), 32'd0);
    step();
    step();

    // 5: asynchronous reset mid-stream
    ifq.deq_ready_i = 1'b0;
    drive(1'b1, 32'h300, 32'h0000_0444);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("prerst_count", 32'(ifq.count_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_deq_valid", 32'(ifq.deq_valid_o), 32'd0);
    check("async_rst_count", 32'(ifq.count_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_count", 32'(ifq.count_o), 32'd0);

    // 6: empty-queue enqueue with decode ready
    ifq.deq_ready_i = 1'b1;
    drive(1'b1, 32'h40, 32'h0050_0093);
    expect_word(32'h40, 32'h0050_0093);
    #1;
    check("byp_deq_valid", 32'(ifq.deq_valid_o), 32'(BYP_VALID));
    check("byp_instr", ifq.instr_o, (BYP_VALID != 0) ? 32'h0050_0093 : NOP_INSTR);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("byp_count", 32'(ifq.count_o), 32'(1 - BYP_VALID));
    step();
    check("byp_end_count", 32'(ifq.count_o), 32'd0);
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
